regfile_wb_arbiter: RTL

Write-port arbiter for the 32×32 register file. Two writeback requesters share the register file's single write port (`we3`/`wa3`/`wd3`): channel A (ALU writeback) and channel B (load/memory writeback). Each channel has a valid/ready handshake and a one-entry holding slot. A round-robin arbiter drains the slots into a registered write port. Writes to R0 are accepted from the requester and then discarded, so R0 never sees a write strobe.

---
 rtl/regfile_wb_arbiter.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: two writeback channels with one-entry slots,
// round-robin drained into a registered write port. Writes to R0 are swallowed.
module regfile_wb_arbiter #(
  parameter int AW = 5,
  parameter int DW = 32,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a_valid,
  output logic          a_ready,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_data,
  input  logic          b_valid,
  output logic          b_ready,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_data,
  output logic          we3,
  output logic [AW-1:0] wa3,
  output logic [DW-1:0] wd3,
  output logic          last_grant,
  output logic [CW-1:0] wr_count
);

  logic          a_full_r;
  logic [AW-1:0] a_addr_r;
  logic [DW-1:0] a_data_r;
  logic          b_full_r;
  logic [AW-1:0] b_addr_r;
  logic [DW-1:0] b_data_r;
  logic          we3_r;
  logic [AW-1:0] wa3_r;
  logic [DW-1:0] wd3_r;
  logic          last_grant_r;
  logic [CW-1:0] wr_count_r;

  logic          grant_a_s;
  logic          grant_b_s;
  logic [AW-1:0] sel_addr_s;
  logic [DW-1:0] sel_data_s;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    if (v == {CW{1'b1}}) begin
      sat_inc = v;
    end else begin
      sat_inc = v + {{(CW-1){1'b0}}, 1'b1};
    end
  endfunction

  // Round-robin grant: on a tie the channel that did not win last time goes.
  always_comb begin
    grant_a_s = 1'b0;
    grant_b_s = 1'b0;
    case ({a_full_r, b_full_r})
      2'b10:   grant_a_s = 1'b1;
      2'b01:   grant_b_s = 1'b1;
      2'b11: begin
        grant_a_s = last_grant_r;
        grant_b_s = ~last_grant_r;
      end
      default: begin
        grant_a_s = 1'b0;
        grant_b_s = 1'b0;
      end
    endcase
  end

  // Mux the granted slot onto the write path.
  always_comb begin
    sel_addr_s = a_addr_r;
    sel_data_s = a_data_r;
    if (grant_b_s) begin
      sel_addr_s = b_addr_r;
      sel_data_s = b_data_r;
    end else begin
      sel_addr_s = a_addr_r;
      sel_data_s = a_data_r;
    end
  end

  // A granted slot frees up in the same cycle, so it may be refilled at once.
  assign a_ready = rst_n & (~a_full_r | grant_a_s);
  assign b_ready = rst_n & (~b_full_r | grant_b_s);

  // Holding slots: load on handshake, clear when drained and not refilled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_full_r <= 1'b0;
      a_addr_r <= {AW{1'b0}};
      a_data_r <= {DW{1'b0}};
      b_full_r <= 1'b0;
      b_addr_r <= {AW{1'b0}};
      b_data_r <= {DW{1'b0}};
    end else begin
      if (a_valid && a_ready) begin
        a_full_r <= 1'b1;
        a_addr_r <= a_addr;
        a_data_r <= a_data;
      end else if (grant_a_s) begin
        a_full_r <= 1'b0;
      end
      if (b_valid && b_ready) begin
        b_full_r <= 1'b1;
        b_addr_r <= b_addr;
        b_data_r <= b_data;
      end else if (grant_b_s) begin
        b_full_r <= 1'b0;
      end
    end
  end

  // Registered write port, grant history and committed-write counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      we3_r        <= 1'b0;
      wa3_r        <= {AW{1'b0}};
      wd3_r        <= {DW{1'b0}};
      last_grant_r <= 1'b1;
      wr_count_r   <= {CW{1'b0}};
    end else if (grant_a_s || grant_b_s) begin
      last_grant_r <= grant_b_s;
      if (sel_addr_s != {AW{1'b0}}) begin
        we3_r      <= 1'b1;
        wa3_r      <= sel_addr_s;
        wd3_r      <= sel_data_s;
        wr_count_r <= sat_inc(wr_count_r);
      end else begin
        we3_r <= 1'b0;
      end
    end else begin
      we3_r <= 1'b0;
    end
  end

  assign we3        = we3_r;
  assign wa3        = wa3_r;
  assign wd3        = wd3_r;
  assign last_grant = last_grant_r;
  assign wr_count   = wr_count_r;

endmodule
